// File: rtl/riscv_wb_retire_pkg.sv
// Shared RISC-V pipeline definitions: major opcodes used at retire and the
// encoding of the halt-pair detector state.
package riscv_wb_retire_pkg;

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        HALT_IDLE   = 2'd0,
        HALT_ARMED  = 2'd1,
        HALT_HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/riscv_halt_detect.sv
// Watches the retiring instruction stream for the two-word halt sequence.
// halt is registered; it rises on the edge that retires the second word.
module riscv_halt_detect
    import riscv_wb_retire_pkg::*;
#(
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        valid,
    input  logic [31:0] inst,
    output logic        halt
);

    halt_state_t state_q;
    halt_state_t state_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= HALT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bubbles hold the state, so an armed detector survives pipeline stalls.
    always_comb begin
        state_d = state_q;
        if (valid) begin
            case (state_q)
                HALT_IDLE: begin
                    if (inst == HALT_INST0) state_d = HALT_ARMED;
                end
                HALT_ARMED: begin
                    if (inst == HALT_INST1)      state_d = HALT_HALTED;
                    else if (inst == HALT_INST0) state_d = HALT_ARMED;
                    else                         state_d = HALT_IDLE;
                end
                HALT_HALTED: state_d = HALT_HALTED;
                default:     state_d = HALT_IDLE;
            endcase
        end
    end

    assign halt = (state_q == HALT_HALTED);

endmodule

// File: rtl/riscv_wb_retire.sv
// Write-back retire observer: instruction counter, last architectural result
// and sticky halt flag. All outputs registered, one cycle after retirement.
module riscv_wb_retire
    import riscv_wb_retire_pkg::*;
#(
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        WB_VALID,
    input  logic [31:0] WB_INST,
    input  logic        WB_RF_WE,
    input  logic [31:0] WB_RF_WD,
    input  logic [31:0] WB_ALU_OUT,
    input  logic        WB_BR_TAKEN,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT
);

    logic        halt;
    logic        retire;
    logic        out_upd;
    logic [31:0] out_d;
    logic [31:0] num_inst_q;
    logic [31:0] output_q;

    riscv_halt_detect #(
        .HALT_INST0 (HALT_INST0),
        .HALT_INST1 (HALT_INST1)
    ) u_halt_detect (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .valid (WB_VALID),
        .inst  (WB_INST),
        .halt  (halt)
    );

    // The second halt word still retires: halt is only seen one edge later.
    assign retire = WB_VALID && !halt;

    always_comb begin
        out_upd = 1'b0;
        out_d   = output_q;
        case (WB_INST[6:0])
            OP_STORE: begin
                out_upd = 1'b1;
                out_d   = WB_ALU_OUT;
            end
            OP_BRANCH: begin
                out_upd = 1'b1;
                out_d   = {31'b0, WB_BR_TAKEN};
            end
            default: begin
                if (WB_RF_WE && (WB_INST[11:7] != 5'd0)) begin
                    out_upd = 1'b1;
                    out_d   = WB_RF_WD;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            num_inst_q <= 32'd0;
            output_q   <= 32'd0;
        end else if (retire) begin
            num_inst_q <= num_inst_q + 32'd1;
            if (out_upd) output_q <= out_d;
        end
    end

    assign NUM_INST    = num_inst_q;
    assign OUTPUT_PORT = output_q;
    assign HALT        = halt;

endmodule

// File: tb/tb_riscv_wb_retire.sv
// Self-checking bench: directed vector table, hand-written wrap/reset sequence,
// and randomized traffic against a behavioural retire model.
module tb_riscv_wb_retire;

    localparam logic [31:0] H0     = 32'h00c00093;
    localparam logic [31:0] H1     = 32'h00008067;
    localparam logic [31:0] I_ADD  = 32'h002081b3;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_BGE  = 32'h0020d463;
    localparam logic [31:0] I_ADDI = 32'h0f000093;
    localparam logic [31:0] I_ADDI2 = 32'h01d00093;
    localparam logic [31:0] I_X0   = 32'h00500013;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        WB_VALID = 1'b0;
    logic [31:0] WB_INST = 32'd0;
    logic        WB_RF_WE = 1'b0;
    logic [31:0] WB_RF_WD = 32'd0;
    logic [31:0] WB_ALU_OUT = 32'd0;
    logic        WB_BR_TAKEN = 1'b0;
    logic [31:0] NUM_INST;
    logic [31:0] OUTPUT_PORT;
    logic        HALT;

    int checks = 0;
    int errors = 0;

    riscv_wb_retire dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .WB_VALID    (WB_VALID),
        .WB_INST     (WB_INST),
        .WB_RF_WE    (WB_RF_WE),
        .WB_RF_WD    (WB_RF_WD),
        .WB_ALU_OUT  (WB_ALU_OUT),
        .WB_BR_TAKEN (WB_BR_TAKEN),
        .NUM_INST    (NUM_INST),
        .OUTPUT_PORT (OUTPUT_PORT),
        .HALT        (HALT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] inst;
        logic        we;
        logic [31:0] wd;
        logic [31:0] alu;
        logic        br;
        logic [31:0] e_num;
        logic [31:0] e_out;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state.
    logic [31:0] m_cnt;
    logic [31:0] m_out;
    logic        m_halted;
    logic [31:0] m_last_valid;
    logic        m_seen_valid;

    function automatic vec_t mk(logic rst, logic vld, logic [31:0] inst, logic we,
                                logic [31:0] wd, logic [31:0] alu, logic br,
                                logic [31:0] e_num, logic [31:0] e_out, logic e_halt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.inst = inst; v.we = we; v.wd = wd;
        v.alu = alu; v.br = br; v.e_num = e_num; v.e_out = e_out; v.e_halt = e_halt;
        return v;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(string name, logic [31:0] e_num, logic [31:0] e_out, logic e_halt);
        check32({name, ".num"}, NUM_INST, e_num);
        check32({name, ".out"}, OUTPUT_PORT, e_out);
        check32({name, ".halt"}, {31'd0, HALT}, {31'd0, e_halt});
    endtask

    task automatic model_reset();
        m_cnt = 0; m_out = 0; m_halted = 0; m_last_valid = 0; m_seen_valid = 0;
    endtask

    // Armed means: the most recent valid word was the first halt word.
    task automatic model_step(logic vld, logic [31:0] inst, logic we, logic [31:0] wd,
                              logic [31:0] alu, logic br);
        logic armed;
        if (!vld || m_halted) return;
        armed = m_seen_valid && (m_last_valid == H0);
        m_cnt = m_cnt + 1;
        if (inst[6:0] == 7'b0100011)      m_out = alu;
        else if (inst[6:0] == 7'b1100011) m_out = br ? 32'd1 : 32'd0;
        else if (we && inst[11:7] != 0)   m_out = wd;
        if (armed && inst == H1) m_halted = 1;
        m_last_valid = inst;
        m_seen_valid = 1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        WB_VALID = 0;
        RSTn = 0;
        @(negedge CLK);
        RSTn = 1;
        model_reset();
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step(logic vld, logic [31:0] inst, logic we, logic [31:0] wd,
                        logic [31:0] alu, logic br);
        WB_VALID = vld; WB_INST = inst; WB_RF_WE = we; WB_RF_WD = wd;
        WB_ALU_OUT = alu; WB_BR_TAKEN = br;
        @(posedge CLK);
        @(negedge CLK);
        model_step(vld, inst, we, wd, alu, br);
    endtask

    initial begin
        // Bubble-interleaved retirement.
        vecs.push_back(mk(1, 1, I_ADDI,  1, 32'h0f00, 0, 0, 1, 32'h0f00, 0));
        vecs.push_back(mk(0, 0, I_ADDI2, 1, 32'h1234, 0, 0, 1, 32'h0f00, 0));
        vecs.push_back(mk(0, 1, I_ADDI2, 1, 32'h001d, 0, 0, 2, 32'h001d, 0));
        // Store and branch observation.
        vecs.push_back(mk(1, 1, I_SW,    0, 32'h9999, 32'h0e54, 0, 1, 32'h0e54, 0));
        vecs.push_back(mk(0, 1, I_BGE,   0, 32'h9999, 32'h7777, 1, 2, 32'h0001, 0));
        vecs.push_back(mk(0, 1, I_BGE,   0, 32'h9999, 32'h7777, 0, 3, 32'h0000, 0));
        // Halt pair with a bubble in between, then post-halt traffic ignored.
        vecs.push_back(mk(1, 1, H0,      1, 32'd12, 0, 0, 1, 32'd12, 0));
        vecs.push_back(mk(0, 0, I_ADD,   1, 32'h55, 0, 0, 1, 32'd12, 0));
        vecs.push_back(mk(0, 1, H1,      0, 32'h0, 0, 0, 2, 32'd12, 1));
        vecs.push_back(mk(0, 1, I_ADD,   1, 32'h55, 0, 0, 2, 32'd12, 1));
        vecs.push_back(mk(0, 1, I_SW,    0, 0, 32'h4444, 0, 2, 32'd12, 1));
        // False arm: a different word between the pair disarms.
        vecs.push_back(mk(1, 1, H0,      1, 32'd12, 0, 0, 1, 32'd12, 0));
        vecs.push_back(mk(0, 1, I_ADD,   1, 32'd7, 0, 0, 2, 32'd7, 0));
        vecs.push_back(mk(0, 1, H1,      0, 32'd0, 0, 0, 3, 32'd7, 0));
        // rd=x0 write and unknown opcode leave the observation value alone.
        vecs.push_back(mk(0, 1, I_X0,    1, 32'd99, 0, 0, 4, 32'd7, 0));
        vecs.push_back(mk(0, 1, 32'h0000007f, 1, 32'd98, 0, 0, 5, 32'd7, 0));
        // Repeated first word keeps it armed.
        vecs.push_back(mk(1, 1, H0,      1, 32'd12, 0, 0, 1, 32'd12, 0));
        vecs.push_back(mk(0, 1, H0,      1, 32'd12, 0, 0, 2, 32'd12, 0));
        vecs.push_back(mk(0, 1, H1,      0, 32'd0, 0, 0, 3, 32'd12, 1));

        RSTn = 0;
        #2;
        check_all("reset", 0, 0, 0);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i].vld, vecs[i].inst, vecs[i].we, vecs[i].wd, vecs[i].alu, vecs[i].br);
            check_all($sformatf("vec%0d", i), vecs[i].e_num, vecs[i].e_out, vecs[i].e_halt);
        end

        // Counter wrap, then reset while armed discards history.
        do_reset();
        force dut.num_inst_q = 32'hffff_ffff;
        #1;
        release dut.num_inst_q;
        step(1, I_ADD, 1, 32'h0abc, 0, 0);
        check_all("wrap", 32'd0, 32'h0abc, 0);
        step(1, H0, 1, 32'd12, 0, 0);
        check_all("armed", 32'd1, 32'd12, 0);
        RSTn = 0;
        #1;
        check_all("async_rst", 0, 0, 0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1;
        model_reset();
        step(1, H1, 0, 32'd0, 0, 0);
        check_all("post_rst_h1", 32'd1, 32'd0, 0);

        // Randomized traffic against the model, with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic        vld;
            logic [31:0] inst;
            int          sel;
            if ($urandom_range(0, 299) == 0) do_reset();
            vld = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    inst = H0;
                2, 3:    inst = H1;
                4:       inst = I_SW;
                5:       inst = I_BGE;
                6:       inst = {$urandom} & 32'hffff_f07f | 32'h0;
                default: inst = $urandom;
            endcase
            step(vld, inst, 1'($urandom), $urandom, $urandom, 1'($urandom));
            check_all($sformatf("rand%0d", n), m_cnt, m_out, m_halted);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
